// File: rtl/alu.sv
// Registered 32-bit integer ALU for the execute stage of a MIPS-style datapath.
// Latency: 1 cycle (combinational compute, outputs registered on rising clk).
// Backpressure: none; a new operation may be issued every cycle, no handshake.
//
// Ports:
//   clk     - system clock, rising-edge active
//   rst_n   - asynchronous active-low reset; clears result and sig_b at once
//   opcode  - instruction opcode field [5:0]
//   rs_val  - first source operand [31:0]
//   rt_val  - second source operand / shift source [31:0]
//   shamt   - constant shift amount for SLL/SRL/SRA [4:0]
//   func    - R-type function field, decoded only when opcode == 0 [5:0]
//   raw_val - raw 16-bit immediate field
//   result  - registered ALU result [31:0]
//   sig_b   - registered branch-taken flag
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] raw_val,
  output logic [31:0] result,
  output logic        sig_b
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] br_off;
  logic [4:0]  var_sh;
  logic        rs_zero;
  logic [31:0] result_d;
  logic        sig_b_d;

  assign sext    = {{16{raw_val[15]}}, raw_val};
  assign zext    = {16'h0000, raw_val};
  assign br_off  = {sext[29:0], 2'b00};
  // Variable shifts use only the low five bits of rs; the rest is ignored.
  assign var_sh  = rs_val[4:0];
  assign rs_zero = (rs_val == 32'd0);

  always_comb begin
    result_d = 32'd0;
    sig_b_d  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (func)
          FN_ADD, FN_ADDU: result_d = rs_val + rt_val;
          FN_SUB, FN_SUBU: result_d = rs_val - rt_val;
          FN_AND:          result_d = rs_val & rt_val;
          FN_OR:           result_d = rs_val | rt_val;
          FN_XOR:          result_d = rs_val ^ rt_val;
          FN_NOR:          result_d = ~(rs_val | rt_val);
          FN_SLT:          result_d = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU:         result_d = {31'd0, rs_val < rt_val};
          FN_SLL:          result_d = rt_val << shamt;
          FN_SRL:          result_d = rt_val >> shamt;
          FN_SRA:          result_d = $unsigned($signed(rt_val) >>> shamt);
          FN_SLLV:         result_d = rt_val << var_sh;
          FN_SRLV:         result_d = rt_val >> var_sh;
          FN_SRAV:         result_d = $unsigned($signed(rt_val) >>> var_sh);
          default:         result_d = 32'd0;
        endcase
      end
      OP_ADDI, OP_ADDIU: result_d = rs_val + sext;
      OP_SLTI:           result_d = {31'd0, $signed(rs_val) < $signed(sext)};
      OP_SLTIU:          result_d = {31'd0, rs_val < sext};
      OP_ANDI:           result_d = rs_val & zext;
      OP_ORI:            result_d = rs_val | zext;
      OP_XORI:           result_d = rs_val ^ zext;
      OP_LUI:            result_d = {raw_val, 16'h0000};
      OP_LW, OP_SW:      result_d = rs_val + sext;
      OP_BEQ: begin
        result_d = br_off;
        sig_b_d  = (rs_val == rt_val);
      end
      OP_BNE: begin
        result_d = br_off;
        sig_b_d  = (rs_val != rt_val);
      end
      OP_BLEZ: begin
        result_d = br_off;
        sig_b_d  = rs_val[31] | rs_zero;
      end
      OP_BGTZ: begin
        result_d = br_off;
        sig_b_d  = ~rs_val[31] & ~rs_zero;
      end
      default: begin
        result_d = 32'd0;
        sig_b_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= 32'd0;
      sig_b  <= 1'b0;
    end else begin
      result <= result_d;
      sig_b  <= sig_b_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for the registered ALU.
// Latency: checks each operation one clock after it is applied.
// Backpressure: not applicable; operations are issued back to back.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [15:0] raw_val;
  logic [31:0] result;
  logic        sig_b;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .shamt   (shamt),
    .func    (func),
    .raw_val (raw_val),
    .result  (result),
    .sig_b   (sig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply an operation, let one rising edge capture it, sample 1 time unit later.
  task automatic do_op(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] raw);
    opcode  = op;
    rs_val  = rs;
    rt_val  = rt;
    shamt   = sh;
    func    = fn;
    raw_val = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'd0; rs_val = 32'd0; rt_val = 32'd0;
    shamt = 5'd0; func = 6'd0; raw_val = 16'd0;

    // Drive a nonzero op under reset: outputs must stay cleared.
    #2;
    opcode = 6'b001000; rs_val = 32'd99; raw_val = 16'd1;
    @(posedge clk); #1;
    check("reset_result", result, 32'd0);
    check("reset_sig_b", {31'd0, sig_b}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // ADDI back to back
    do_op(6'b001000, 32'd15, 32'd0, 5'd0, 6'd0, 16'd13);
    check("addi_15_13", result, 32'd28);
    check("addi_15_13_sig_b", {31'd0, sig_b}, 32'd0);
    do_op(6'b001000, 32'd23, 32'd0, 5'd0, 6'd0, 16'd19);
    check("addi_23_19", result, 32'd42);
    check("addi_23_19_sig_b", {31'd0, sig_b}, 32'd0);
    do_op(6'b001000, 32'd12, 32'd0, 5'd0, 6'd0, 16'd10);
    check("addi_12_10", result, 32'd22);
    check("addi_12_10_sig_b", {31'd0, sig_b}, 32'd0);

    // Immediate extension
    do_op(6'b001000, 32'd5, 32'd0, 5'd0, 6'd0, 16'hFFFF);
    check("addi_sext", result, 32'd4);
    do_op(6'b001101, 32'd0, 32'd0, 5'd0, 6'd0, 16'hFFFF);
    check("ori_zext", result, 32'h0000FFFF);
    do_op(6'b001111, 32'hFFFFFFFF, 32'd0, 5'd0, 6'd0, 16'h1234);
    check("lui", result, 32'h12340000);
    do_op(6'b001100, 32'hFFFFFFFF, 32'd0, 5'd0, 6'd0, 16'h8001);
    check("andi_zext", result, 32'h00008001);
    do_op(6'b001011, 32'd5, 32'd0, 5'd0, 6'd0, 16'hFFFF);
    check("sltiu_sext", result, 32'd1);
    do_op(6'b001010, 32'd5, 32'd0, 5'd0, 6'd0, 16'hFFFF);
    check("slti_sext", result, 32'd0);
    do_op(6'b100011, 32'd100, 32'd0, 5'd0, 6'd0, 16'hFFFC);
    check("lw_addr", result, 32'd96);

    // R-type arithmetic, logic, compare
    do_op(6'b000000, 32'd3, 32'd5, 5'd0, 6'b100010, 16'd0);
    check("sub_3_5", result, 32'hFFFFFFFE);
    do_op(6'b000000, 32'd0, 32'd0, 5'd0, 6'b100111, 16'd0);
    check("nor_0_0", result, 32'hFFFFFFFF);
    do_op(6'b000000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 6'b100110, 16'd0);
    check("xor", result, 32'hFF00_0FF0);
    do_op(6'b000000, 32'h80000000, 32'd1, 5'd0, 6'b101010, 16'd0);
    check("slt_neg_1", result, 32'd1);
    do_op(6'b000000, 32'h80000000, 32'd1, 5'd0, 6'b101011, 16'd0);
    check("sltu_neg_1", result, 32'd0);
    do_op(6'b000000, 32'h80000000, 32'd0, 5'd0, 6'b101010, 16'd0);
    check("slt_neg_0", result, 32'd1);
    do_op(6'b000000, 32'h80000000, 32'd0, 5'd0, 6'b101011, 16'd0);
    check("sltu_neg_0", result, 32'd0);
    do_op(6'b000000, 32'h7FFFFFFF, 32'd1, 5'd0, 6'b100000, 16'd0);
    check("add_wrap", result, 32'h80000000);
    check("add_wrap_sig_b", {31'd0, sig_b}, 32'd0);
    do_op(6'b000000, 32'd9, 32'd9, 5'd0, 6'b111111, 16'd0);
    check("func_unknown", result, 32'd0);
    check("rtype_eq_sig_b", {31'd0, sig_b}, 32'd0);

    // Shifts
    do_op(6'b000000, 32'd0, 32'd1, 5'd31, 6'b000000, 16'd0);
    check("sll_31", result, 32'h80000000);
    do_op(6'b000000, 32'd0, 32'hDEADBEEF, 5'd0, 6'b000000, 16'd0);
    check("sll_0", result, 32'hDEADBEEF);
    do_op(6'b000000, 32'd0, 32'h80000000, 5'd4, 6'b000011, 16'd0);
    check("sra_4", result, 32'hF8000000);
    do_op(6'b000000, 32'd0, 32'h80000000, 5'd4, 6'b000010, 16'd0);
    check("srl_4", result, 32'h08000000);
    do_op(6'b000000, 32'd36, 32'h000000F0, 5'd0, 6'b000110, 16'd0);
    check("srlv_36", result, 32'h0000000F);
    do_op(6'b000000, 32'h00000104, 32'h80000000, 5'd0, 6'b000111, 16'd0);
    check("srav_4", result, 32'hF8000000);
    do_op(6'b000000, 32'd35, 32'd1, 5'd0, 6'b000100, 16'd0);
    check("sllv_3", result, 32'd8);

    // Branches
    do_op(6'b000100, 32'd7, 32'd7, 5'd0, 6'd0, 16'd3);
    check("beq_taken_sig_b", {31'd0, sig_b}, 32'd1);
    check("beq_offset", result, 32'd12);
    do_op(6'b000101, 32'd7, 32'd7, 5'd0, 6'd0, 16'd3);
    check("bne_not_taken", {31'd0, sig_b}, 32'd0);
    check("bne_offset", result, 32'd12);
    do_op(6'b000101, 32'd7, 32'd8, 5'd0, 6'd0, 16'hFFFF);
    check("bne_taken", {31'd0, sig_b}, 32'd1);
    check("bne_neg_offset", result, 32'hFFFFFFFC);
    do_op(6'b000111, 32'd0, 32'd0, 5'd0, 6'd0, 16'd1);
    check("bgtz_zero", {31'd0, sig_b}, 32'd0);
    do_op(6'b000111, 32'd1, 32'd0, 5'd0, 6'd0, 16'd1);
    check("bgtz_pos", {31'd0, sig_b}, 32'd1);
    do_op(6'b000110, 32'hFFFFFFFF, 32'd0, 5'd0, 6'd0, 16'd1);
    check("blez_neg", {31'd0, sig_b}, 32'd1);
    do_op(6'b000110, 32'd1, 32'd0, 5'd0, 6'd0, 16'd1);
    check("blez_pos", {31'd0, sig_b}, 32'd0);
    do_op(6'b111111, 32'd7, 32'd7, 5'd0, 6'd0, 16'd3);
    check("op_unknown_result", result, 32'd0);
    check("op_unknown_sig_b", {31'd0, sig_b}, 32'd0);

    // Async reset between edges
    do_op(6'b000000, 32'd1, 32'd1, 5'd0, 6'b100000, 16'd0);
    check("add_1_1", result, 32'd2);
    do_op(6'b000100, 32'd4, 32'd4, 5'd0, 6'd0, 16'd1);
    check("pre_reset_sig_b", {31'd0, sig_b}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_result", result, 32'd0);
    check("async_reset_sig_b", {31'd0, sig_b}, 32'd0);
    @(posedge clk); #1;
    check("reset_hold_result", result, 32'd0);
    check("reset_hold_sig_b", {31'd0, sig_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(6'b000000, 32'd1, 32'd1, 5'd0, 6'b100000, 16'd0);
    check("post_reset_add", result, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU for the MIPS-style datapath, located in the execute stage.
- Decodes OPCODE and FUNC, computes RESULT from RS_VAL, RT_VAL, SHAMT and the 16-bit immediate RAW_VAL.
- Raises SIG_B when a conditional branch is taken.
- Outputs are registered: one clock of latency, async active-low reset.

Parameters:
- None; data width is fixed at 32 bits and immediate width at 16 bits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- OPCODE  input  6  instruction opcode field.
- RS_VAL  input  32  first source operand.
- RT_VAL  input  32  second source operand; also the shift source.
- SHAMT  input  5  constant shift amount for SLL/SRL/SRA.
- FUNC  input  6  R-type function field, used only when OPCODE=000000.
- RAW_VAL  input  16  raw immediate field.
- RESULT  output  32  registered ALU result.
- SIG_B  output  1  registered branch-taken flag.

Behaviour:
- RST_N low: RESULT=0 and SIG_B=0 immediately, without waiting for a clock edge. Both are held at 0 while RST_N is low.
- First rising edge after RST_N rises: outputs capture the value computed from the inputs present at that edge.
- Latency: combinational compute, registered at the rising edge; result visible 1 cycle after the inputs are applied. A new operation may be issued every cycle. No handshake.
- Immediate extension:
  - SEXT = RAW_VAL sign-extended to 32 bits.
  - ZEXT = RAW_VAL zero-extended to 32 bits.
- All add/sub wrap modulo 2^32. Signed and unsigned variants give identical RESULT. No overflow trap or flag.
- R-type operations (OPCODE=000000), selected by FUNC:
  - 100000 ADD / 100001 ADDU: RS+RT.
  - 100010 SUB / 100011 SUBU: RS-RT.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise RS op RT.
  - 101010 SLT: 1 if RS<RT signed, else 0.
  - 101011 SLTU: 1 if RS<RT unsigned, else 0.
  - 000000 SLL: RT<<SHAMT.
  - 000010 SRL: RT>>SHAMT, logical.
  - 000011 SRA: RT>>SHAMT, arithmetic.
  - 000100 SLLV / 000110 SRLV / 000111 SRAV: same shifts by RS[4:0]; upper bits of RS are ignored.
  - Any other FUNC: RESULT=0.
  - SIG_B=0 for all R-type operations.
- I-type operations:
  - 001000 ADDI / 001001 ADDIU: RS+SEXT.
  - 001010 SLTI: RS<SEXT signed. 001011 SLTIU: RS<SEXT unsigned.
  - 001100 ANDI: RS&ZEXT. 001101 ORI: RS|ZEXT. 001110 XORI: RS^ZEXT.
  - 001111 LUI: {RAW_VAL,16'h0000}.
  - 100011 LW / 101011 SW: RS+SEXT, the effective address.
- Branch operations:
  - RESULT = SEXT<<2 (byte offset) for all four.
  - 000100 BEQ: SIG_B = (RS==RT).
  - 000101 BNE: SIG_B = (RS!=RT).
  - 000110 BLEZ: SIG_B = (RS signed <= 0).
  - 000111 BGTZ: SIG_B = (RS signed > 0).
- SIG_B=0 for every non-branch opcode.
- Unknown OPCODE: RESULT=0, SIG_B=0.
- Boundaries:
  - Shift by 0 returns RT unchanged.
  - 32'h7FFFFFFF+1 gives 32'h80000000 with no side effect.
  - SLT(32'h80000000, 0)=1; SLTU of the same operands gives 0.
- Reset asserted mid-stream: outputs clear at once and the pending computation is discarded.

Test Plan:
- Reset and ADDI: RST_N=0 → RESULT=0, SIG_B=0. Release, then issue OPCODE=001000 with RS=15/RAW=13, RS=23/RAW=19, RS=12/RAW=10 on successive edges → RESULT=28, 42, 22, each one cycle later; SIG_B=0 throughout.
- Immediate extension: ADDI RS=5, RAW=16'hFFFF → 4. ORI RS=0, RAW=16'hFFFF → 32'h0000FFFF. LUI RAW=16'h1234 → 32'h12340000.
- R-type arithmetic, logic and compare: SUB 3-5 → 32'hFFFFFFFE. NOR 0,0 → 32'hFFFFFFFF. SLT 32'h80000000 vs 1 → 1. SLTU with the same operands → 0. Unknown FUNC 111111 → 0.
- Shifts: SLL RT=1, SHAMT=31 → 32'h80000000. SRA RT=32'h80000000, SHAMT=4 → 32'hF8000000. SRLV RS=36, RT=32'hF0 → 32'h0F, since the shift is by 4.
- Branches: BEQ RS=RT=7, RAW=3 → SIG_B=1, RESULT=12. BNE with the same operands → SIG_B=0. BGTZ RS=0 → 0. BLEZ RS=32'hFFFFFFFF → 1.
- Async reset mid-operation: drive ADD 1+1 and assert RST_N between clock edges → RESULT drops to 0 before the next edge and stays 0 until release.
